// File: rtl/sar_sample_averager_if.sv
// sar_sample_averager_if: block result bus with valid/ready handshake and overrun flag
interface sar_sample_averager_if #(
    parameter int DW = 8
);
    logic [DW-1:0] avg_data;
    logic [DW-1:0] avg_min;
    logic [DW-1:0] avg_max;
    logic          avg_valid;
    logic          avg_ready;
    logic          overrun;

    modport master (
        output avg_data, avg_min, avg_max, avg_valid, overrun,
        input  avg_ready
    );

    modport slave (
        input  avg_data, avg_min, avg_max, avg_valid, overrun,
        output avg_ready
    );
endinterface

// File: rtl/sar_sample_averager.sv
// sar_sample_averager: block average/min/max of synchronized SAR ADC samples
module sar_sample_averager #(
    parameter int LOG2N = 4,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DW-1:0]        adc_data,
    input  logic                 adc_done,
    sar_sample_averager_if.master res
);
    localparam int AW = DW + LOG2N;
    localparam int CW = LOG2N > 0 ? LOG2N : 1;
    localparam logic [CW-1:0] LAST = CW'((1 << LOG2N) - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t        state, state_n;
    logic [2:0]    sync;
    logic          smp, last, done;
    logic [AW-1:0] acc, sum;
    logic [CW-1:0] cnt;
    logic [DW-1:0] mn, mx, mn_n, mx_n;

    assign smp = sync[1] & ~sync[2];

    // two flops resolve metastability on adc_done, the third detects its rising edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= '0;
        else        sync <= {sync[1:0], adc_done};

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    // next state, block-end detection and the running sum/min/max including the current sample
    always_comb begin
        state_n = en ? ACCUM : IDLE;
        last    = cnt == LAST;
        done    = state == ACCUM && smp && last;
        sum     = acc + AW'(adc_data);
        mn_n    = (cnt == '0 || adc_data < mn) ? adc_data : mn;
        mx_n    = (cnt == '0 || adc_data > mx) ? adc_data : mx;
    end

    // accumulate samples, publish completed blocks and run the result handshake
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc           <= '0;
            cnt           <= '0;
            mn            <= '0;
            mx            <= '0;
            res.avg_data  <= '0;
            res.avg_min   <= '0;
            res.avg_max   <= '0;
            res.avg_valid <= 1'b0;
            res.overrun   <= 1'b0;
        end else if (state == IDLE) begin
            acc           <= '0;
            cnt           <= '0;
            mn            <= '0;
            mx            <= '0;
            res.avg_data  <= '0;
            res.avg_min   <= '0;
            res.avg_max   <= '0;
            res.avg_valid <= 1'b0;
            res.overrun   <= 1'b0;
        end else begin
            if (smp) begin
                acc <= last ? '0 : sum;
                cnt <= last ? '0 : cnt + CW'(1);
                mn  <= mn_n;
                mx  <= mx_n;
            end
            if (done) begin
                res.avg_data  <= DW'(sum >> LOG2N);
                res.avg_min   <= mn_n;
                res.avg_max   <= mx_n;
                res.avg_valid <= 1'b1;
                if (res.avg_valid && !res.avg_ready) res.overrun <= 1'b1;
            end else if (res.avg_valid && res.avg_ready) begin
                res.avg_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_sar_sample_averager.sv
// tb_sar_sample_averager: randomized check of three averager configurations against a sample-list model
module tb_sar_sample_averager;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       adc_done = 1'b0;
    logic [7:0] adc_data = 8'd0;

    always #5 clk = ~clk;

    sar_sample_averager_if #(.DW(8)) r0 ();
    sar_sample_averager_if #(.DW(8)) r1 ();
    sar_sample_averager_if #(.DW(8)) r2 ();

    sar_sample_averager #(.LOG2N(2), .DW(8)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .adc_data(adc_data), .adc_done(adc_done), .res(r0)
    );
    sar_sample_averager #(.LOG2N(8), .DW(8)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .adc_data(adc_data), .adc_done(adc_done), .res(r1)
    );
    sar_sample_averager #(.LOG2N(0), .DW(8)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .adc_data(adc_data), .adc_done(adc_done), .res(r2)
    );

    int lg[3] = '{2, 8, 0};
    int hist[3][256];
    int n[3];
    int ea[3], emn[3], emx[3];
    bit ev[3], eo[3];
    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(string tag, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr_model();
        for (int i = 0; i < 3; i++) begin
            n[i] = 0; ea[i] = 0; emn[i] = 0; emx[i] = 0; ev[i] = 0; eo[i] = 0;
        end
    endtask

    task automatic model(int s, bit rdy0);
        for (int i = 0; i < 3; i++) begin
            bit rdy;
            rdy = (i == 0) && rdy0;
            hist[i][n[i]] = s;
            n[i]++;
            if (n[i] == (1 << lg[i])) begin
                int sm, lo, hi;
                sm = 0; lo = 255; hi = 0;
                for (int k = 0; k < n[i]; k++) begin
                    sm += hist[i][k];
                    if (hist[i][k] < lo) lo = hist[i][k];
                    if (hist[i][k] > hi) hi = hist[i][k];
                end
                if (ev[i] && !rdy) eo[i] = 1;
                ea[i] = sm / n[i]; emn[i] = lo; emx[i] = hi; ev[i] = 1; n[i] = 0;
            end else if (rdy) begin
                ev[i] = 0;
            end
        end
    endtask

    task automatic cmp(string tag, int i, logic [7:0] d, logic [7:0] lo, logic [7:0] hi, logic v, logic o);
        chk($sformatf("%s%0d.data", tag, i), d, ea[i]);
        chk($sformatf("%s%0d.min", tag, i), lo, emn[i]);
        chk($sformatf("%s%0d.max", tag, i), hi, emx[i]);
        chk($sformatf("%s%0d.valid", tag, i), v, ev[i]);
        chk($sformatf("%s%0d.overrun", tag, i), o, eo[i]);
    endtask

    task automatic cmp_all(string tag);
        cmp(tag, 0, r0.avg_data, r0.avg_min, r0.avg_max, r0.avg_valid, r0.overrun);
        cmp(tag, 1, r1.avg_data, r1.avg_min, r1.avg_max, r1.avg_valid, r1.overrun);
        cmp(tag, 2, r2.avg_data, r2.avg_min, r2.avg_max, r2.avg_valid, r2.overrun);
    endtask

    task automatic send(int s, bit al);
        @(posedge clk);
        #1 adc_data = 8'(s);
        adc_done = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 chk("lat.valid", r0.avg_valid, ev[0]);
        if (al) r0.avg_ready = 1'b1;
        @(posedge clk);
        #1 r0.avg_ready = 1'b0;
        model(s, al);
        cmp_all("smp");
        adc_done = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic en_pulse();
        @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        #1 clr_model();
        cmp_all("en");
    endtask

    task automatic hold_accept();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1 chk("hold.valid", r0.avg_valid, 1);
            chk("hold.data", r0.avg_data, ea[0]);
        end
        r0.avg_ready = 1'b1;
        @(posedge clk);
        #1 r0.avg_ready = 1'b0;
        ev[0] = 0;
        cmp_all("acc");
    endtask

    initial begin
        r0.avg_ready = 1'b0;
        r1.avg_ready = 1'b0;
        r2.avg_ready = 1'b0;
        clr_model();
        #12 cmp_all("rst");
        en = 1'b1;
        #10 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        send(10, 0); send(20, 0); send(30, 0); send(41, 0);
        chk("blk.avg", r0.avg_data, 25);
        chk("blk.min", r0.avg_min, 10);
        chk("blk.max", r0.avg_max, 41);
        hold_accept();

        en_pulse();
        repeat (4) send(5, 0);
        repeat (4) send(9, 0);
        chk("ovr.data", r0.avg_data, 9);
        chk("ovr.valid", r0.avg_valid, 1);
        chk("ovr.flag", r0.overrun, 1);
        en_pulse();
        chk("ovr.clear", r0.overrun, 0);

        repeat (7) send($urandom_range(0, 255), 0);
        send($urandom_range(0, 255), 1);
        chk("ca.valid", r0.avg_valid, 1);
        chk("ca.overrun", r0.overrun, 0);

        en_pulse();
        repeat (2) send($urandom_range(0, 255), 0);
        en_pulse();
        repeat (4) send($urandom_range(0, 255), 0);

        repeat (40) send($urandom_range(0, 255), $urandom_range(0, 3) == 0);

        en_pulse();
        repeat (6) send($urandom_range(0, 255), 0);
        chk("arst.pre", r0.avg_valid, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 clr_model();
        cmp_all("arst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        repeat (3) send($urandom_range(0, 255), 0);
        chk("post.valid", r0.avg_valid, 0);
        send($urandom_range(0, 255), 0);

        en_pulse();
        repeat (256) send(255, 0);
        chk("l8.avg", r1.avg_data, 255);
        chk("l8.valid", r1.avg_valid, 1);

        send(7, 0);
        chk("l0.first", r2.avg_data, 7);
        send(200, 0);
        chk("l0.data", r2.avg_data, 200);
        chk("l0.min", r2.avg_min, 200);
        chk("l0.max", r2.avg_max, 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sar_sample_averager.md
# sar_sample_averager

Downstream consumer of the SAR ADC conversion stage. Captures each 8-bit conversion result when the ADC's `done` strobe rises. Averages blocks of 2^LOG2N consecutive samples and tracks the per-block minimum and maximum. Presents each block result on a valid/ready interface to the readout logic. The ADC `done` is not generated in the `clk` domain, so this block synchronizes it before use.

## Interface
Parameters:
- `LOG2N`, default 4: log2 of samples per block; legal range 0..8.
- `DW`, default 8: sample width; must match ADC output width.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: block enable; low clears the block (same role as the ADC enable on `ui_in[0]`).
- `adc_data`, input, DW: conversion result, held stable from `adc_done` rise until the next rise.
- `adc_done`, input, 1: ADC done strobe, asynchronous to `clk`.
- `avg_data`, output, DW: block average, `(sum >> LOG2N)`, truncated.
- `avg_min`, output, DW: smallest sample in the block.
- `avg_max`, output, DW: largest sample in the block.
- `avg_valid`, output, 1: result available.
- `avg_ready`, input, 1: consumer accepts the result.
- `overrun`, output, 1: sticky flag; a result was overwritten before acceptance.

## Operation
- **Synchronizer.** `adc_done` passes through a 2-flop synchronizer and then a third flop. Strobe `smp = sync2 & ~sync3` is one cycle per rising edge.
- **States.**
  - IDLE: entered when `en`=0, or from reset.
  - ACCUM: entered on the first cycle with `en`=1.
  - ACCUM → IDLE whenever `en`=0.
- **IDLE.**
  - Accumulator, sample count, running min/max, `avg_valid` and `overrun` are cleared.
  - `avg_data`, `avg_min` and `avg_max` are set to 0.
  - Strobes are ignored.
- **ACCUM, on `smp`.**
  - `acc += adc_data`, where `acc` is DW+LOG2N bits wide and can never overflow.
  - min/max are updated.
  - `cnt` is incremented modulo 2^LOG2N.
  - The first sample of a block loads min = max = sample rather than comparing against stale values.
- **Block completion.** When `smp` arrives with `cnt` = 2^LOG2N−1:
  - Output registers load `(acc+adc_data)>>LOG2N` and the final min/max, including the current sample.
  - `avg_valid` is set.
  - acc, cnt and min/max restart for the next block in the same cycle. No sample is lost between blocks.
- **LOG2N=0.** Every sample is a complete block: `avg_data` = `avg_min` = `avg_max` = sample.
- **Handshake.**
  - `avg_valid` stays high and the outputs stay stable until a cycle with `avg_valid & avg_ready`.
  - `avg_valid` clears on the following edge.
  - `avg_ready` may be high while `avg_valid` is low; this has no effect.
- **Overrun.** A block completes while `avg_valid`=1 and `avg_ready`=0 in that cycle.
  - The outputs are overwritten with the new result.
  - `avg_valid` stays 1.
  - `overrun` is set and held until `en`=0 or reset.
- **Simultaneous completion and acceptance.** The old result is accepted, the new result is loaded, `avg_valid` stays 1, and `overrun` is not set.
- **`en` rising.** Only strobes occurring at least one cycle after `en` is high count. A strobe already in flight in the synchronizer is dropped if it fires while `en`=0.

## Timing
- Reset values: every output is 0; synchronizer flops are 0.
- Capture latency: `adc_done` first sampled high at edge k → `smp` high in cycle k+1 → accumulate at edge k+2.
- Result latency: `avg_valid` rises at edge k+2 of the block's final sample.
- Input timing requirements:
  - `adc_done` high and low phases: each ≥ 2 `clk` periods.
  - `adc_data` stable from the `adc_done` rise until ≥ 3 `clk` edges later.
- Throughput: one sample per 4 `clk` cycles minimum; no backpressure to the ADC.
- Asynchronous reset mid-block: immediate clear of all state; after release, operation starts in IDLE and moves to ACCUM on the first edge with `en`=1.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-block with `avg_valid`=1 → all outputs 0 immediately. After release with `en`=1, the first block needs a full 2^LOG2N samples.
- **Block average (LOG2N=2).** Samples 10, 20, 30, 41 → `avg_data`=25 (101>>2), `avg_min`=10, `avg_max`=41. `avg_valid` rises exactly 2 edges after the 4th `adc_done` is sampled high.
- **Handshake hold.** Hold `avg_ready`=0 for 5 cycles, then raise it for 1 cycle → outputs stable and valid for all 5 cycles; `avg_valid`=0 on the edge after the accept cycle; `overrun`=0.
- **Overrun.** Tie `avg_ready`=0 and run 2 blocks (5,5,5,5 then 9,9,9,9) → after the second block `avg_data`=9, `avg_valid`=1, `overrun`=1. Pulse `en` low → `overrun`=0.
- **Completion plus acceptance.** Align `avg_ready`=1 with a block completion → `avg_valid` stays 1, new data loaded, `overrun`=0.
- **`en` and extremes.**
  - Drop `en` after 2 samples of a block → counters clear; the next 2^LOG2N samples form a fresh block with no carry-over.
  - LOG2N=8 with all samples 255 → `avg_data`=255, no overflow.
  - LOG2N=0 with samples 7, 200 → two results, each equal to its sample.
